leading_count_iter: RTL and testbench

//  Iterative count-leading-zeros/ones unit for the CLZ/CLO instructions.

---
 rtl/shift_pkg.sv | 15 +
 rtl/leading_count_step.sv | 20 ++
 rtl/leading_count_iter.sv | 144 ++++++++++++++
 tb/tb_leading_count_iter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/normalise functional units.
package shift_pkg;

  typedef enum logic [1:0] {
    LC_IDLE,
    LC_SEARCH,
    LC_DONE
  } lc_state_t;

  // Width of a leading-count result able to hold 0..width inclusive.
  function automatic int count_rw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/leading_count_step.sv
// One binary-search halving: tests whether the top h bits of w are all zero
// and provides w shifted left by h for the case where they are.
module leading_count_step #(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_w,
  input  logic [LOG2W-1:0] i_h,
  output logic             o_zero_hit,
  output logic [WIDTH-1:0] o_w_shifted
);

  logic [WIDTH-1:0] w_mask;

  // Mask selecting the top h bits of the window.
  assign w_mask      = ~({WIDTH{1'b1}} >> i_h);
  assign o_zero_hit  = (i_w & w_mask) == '0;
  assign o_w_shifted = i_w << i_h;

endmodule

// File: rtl/leading_count_iter.sv
// Iterative count-leading-zeros/ones unit. CLO is handled by inverting the
// operand at accept time, so the search itself only ever counts zeros.
// One halving step per cycle; valid/ready handshake on both sides.
module leading_count_iter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int RW    = count_rw(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             count_ones,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    result,
  output logic             busy
);

  localparam int               LOG2W     = $clog2(WIDTH);
  localparam logic [LOG2W-1:0] HALF      = LOG2W'(WIDTH / 2);
  localparam logic [LOG2W-1:0] LAST_STEP = LOG2W'(LOG2W - 1);
  localparam logic [LOG2W-1:0] STEP_ONE  = LOG2W'(1);
  localparam logic [RW-1:0]    CNT_ONE   = RW'(1);

  lc_state_t        r_state;
  lc_state_t        w_next_state;
  logic [WIDTH-1:0] r_w;
  logic [RW-1:0]    r_cnt;
  logic [LOG2W-1:0] r_step;

  logic [LOG2W-1:0] w_h;
  logic             w_zero_hit;
  logic [WIDTH-1:0] w_w_shifted;
  logic [WIDTH-1:0] w_w_next;
  logic [RW-1:0]    w_add_h;
  logic [RW-1:0]    w_add_1;
  logic [RW-1:0]    w_cnt_next;
  logic             w_last;
  logic             w_accept;
  logic             w_search;

  // h = WIDTH >> (step+1), written as (WIDTH/2) >> step to stay in LOG2W bits.
  assign w_h    = HALF >> r_step;
  assign w_last = (r_step == LAST_STEP);

  leading_count_step #(
    .WIDTH (WIDTH),
    .LOG2W (LOG2W)
  ) u_step (
    .i_w         (r_w),
    .i_h         (w_h),
    .o_zero_hit  (w_zero_hit),
    .o_w_shifted (w_w_shifted)
  );

  // Count update: add h on a zero window; on the final step also add one
  // more if the remaining MSB is still zero (covers the all-zero word).
  always_comb begin
    w_w_next   = w_zero_hit ? w_w_shifted : r_w;
    w_add_h    = w_zero_hit ? {1'b0, w_h} : '0;
    w_add_1    = (w_last && !w_w_next[WIDTH-1]) ? CNT_ONE : '0;
    w_cnt_next = r_cnt + w_add_h + w_add_1;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= LC_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; flush overrides any accept or handshake.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_search     = 1'b0;
    case (r_state)
      LC_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = LC_SEARCH;
        end
      end
      LC_SEARCH: begin
        w_search = 1'b1;
        if (w_last) begin
          w_next_state = LC_DONE;
        end
      end
      LC_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept     = 1'b1;
            w_next_state = LC_SEARCH;
          end else begin
            w_next_state = LC_IDLE;
          end
        end
      end
      default: begin
        w_next_state = LC_IDLE;
      end
    endcase
    if (flush) begin
      w_next_state = LC_IDLE;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      w_search     = 1'b0;
    end
  end

  // Working word, running count and step index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_w    <= '0;
      r_cnt  <= '0;
      r_step <= '0;
    end else if (w_accept) begin
      r_w    <= count_ones ? ~data_in : data_in;
      r_cnt  <= '0;
      r_step <= '0;
    end else if (w_search) begin
      r_w    <= w_w_next;
      r_cnt  <= w_cnt_next;
      r_step <= r_step + STEP_ONE;
    end
  end

  assign result = r_cnt;
  assign busy   = (r_state != LC_IDLE);

endmodule

// File: tb/tb_leading_count_iter.sv
// Directed-vector bench for leading_count_iter with a scoreboard queue:
// the driver pushes expected results at accept, the monitor pops at handshake.
module tb_leading_count_iter;

  localparam int WIDTH = 32;
  localparam int LOG2W = 5;
  localparam int RW    = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             count_ones;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;
  logic             busy;

  typedef struct {
    int res;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_hs = -1;
  bit   seen    = 1'b0;

  leading_count_iter #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .count_ones (count_ones),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency on first sight of a result, stability under backpressure,
  // value compare at the handshake.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d, required no output", result);
      end else begin
        if (!seen) begin
          check("latency", cyc - sb[0].acc, LOG2W);
          seen = 1'b1;
        end
        if (out_ready) begin
          check("result", int'(result), sb[0].res);
          last_hs = cyc + 1;
          void'(sb.pop_front());
          seen = 1'b0;
        end else begin
          check("hold_result", int'(result), sb[0].res);
          check("hold_in_ready", int'(in_ready), 0);
        end
      end
    end
  end

  // Offer an operand until accepted; optionally record its expected result.
  task automatic send(input logic [WIDTH-1:0] d, input logic co, input int req, input bit push);
    bit ok = 1'b0;
    in_valid   = 1'b1;
    data_in    = d;
    count_ones = co;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) begin
        if (push) sb.push_back('{res: req, acc: cyc + 1});
        ok = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0, required 1");
    end
  endtask

  // Wait (bounded) for the scoreboard to empty and the unit to go idle.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) break;
    end
    check("drain", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] d, input logic co, input int req);
    send(d, co, req, 1'b1);
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    count_ones = 1'b0;
    out_ready  = 1'b1;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    #6 reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic CLZ / CLO vectors
    run_op(32'h0001_0000, 1'b0, 15);
    run_op(32'h0000_0000, 1'b0, 32);
    run_op(32'h8000_0000, 1'b0, 0);
    run_op(32'h0000_0001, 1'b0, 31);
    run_op(32'hF000_0000, 1'b1, 4);
    run_op(32'hFFFF_FFFF, 1'b1, 32);
    run_op(32'h7FFF_FFFF, 1'b1, 0);

    // Backpressure: result held for 10 cycles, then release to IDLE
    out_ready = 1'b0;
    send(32'h0001_0000, 1'b0, 15, 1'b1);
    in_valid = 1'b0;
    repeat (15) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_busy", int'(busy), 1);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("bp_idle_busy", int'(busy), 0);
    check("bp_idle_out_valid", int'(out_valid), 0);
    @(posedge clock);
    #1;

    // Back-to-back with in_valid held
    send(32'h00FF_0000, 1'b0, 8, 1'b1);
    send(32'h0000_0F00, 1'b0, 20, 1'b1);
    check("b2b_accept_edge", (sb.size() > 0) ? sb[0].acc : -1, last_hs);
    in_valid = 1'b0;
    drain();

    // Flush at SEARCH step 2
    send(32'h0001_0000, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_busy", int'(busy), 0);
    repeat (8) begin
      @(negedge clock);
      check("flush_no_valid", int'(out_valid), 0);
    end
    @(posedge clock);
    #1;

    // Async reset pulse mid-SEARCH
    send(32'h0001_0000, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    check("areset_busy", int'(busy), 0);
    check("areset_in_ready", int'(in_ready), 1);
    check("areset_out_valid", int'(out_valid), 0);
    check("areset_result", int'(result), 0);
    #1 reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      check("areset_no_valid", int'(out_valid), 0);
    end
    @(posedge clock);
    #1;

    run_op(32'h0000_0100, 1'b0, 23);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
